// File: rtl/cmos_rgb565_capture.sv
// OV5640 DVP capture front end: registers the sensor bus, pairs bytes into RGB565
// words, gates capture on frame boundaries and reports per-frame geometry errors.
module cmos_rgb565_capture #(
    parameter int unsigned H_ACT      = 1920,
    parameter int unsigned V_ACT      = 1080,
    parameter int unsigned FRAME_SKIP = 8,
    parameter bit          VSYNC_POL  = 1'b1
) (
    input  logic        cmos_pclk,
    input  logic        rst,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    input  logic        capture_en,
    output logic        o_wr_en,
    output logic [15:0] o_wr_data,
    output logic        o_frame_start,
    output logic        o_frame_done,
    output logic        o_frame_err,
    output logic [7:0]  o_frame_cnt
);

    typedef enum logic [1:0] {
        SKIP   = 2'd0,
        WAIT   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [11:0] H_LIM    = 12'(H_ACT);
    localparam logic [11:0] V_LIM    = 12'(V_ACT);
    localparam logic [11:0] CNT_MAX  = '1;
    localparam logic [15:0] SKIP_LIM = 16'(FRAME_SKIP);

    state_t      state;
    state_t      state_nxt;

    logic        vs_r;
    logic        hs_r;
    logic [7:0]  d_r;
    logic        vs_n;
    logic        vs_n_d;
    logic        in_line;
    logic        in_line_d;
    logic        fs;
    logic        line_end;

    logic        phase;
    logic [7:0]  hi_byte;
    logic [11:0] pix_cnt;
    logic [11:0] line_cnt;
    logic        err_acc;
    logic [15:0] skip_cnt;

    logic        start_c;
    logic        done_c;
    logic        skip_inc;

    assign vs_n     = VSYNC_POL ? vs_r : ~vs_r;
    assign fs       = vs_n & ~vs_n_d;
    // href seen while vsync is active is not part of a line
    assign in_line  = hs_r & ~vs_n;
    assign line_end = in_line_d & ~in_line & (state == ACTIVE);

    always_ff @(posedge cmos_pclk or posedge rst) begin
        if (rst) begin
            state <= SKIP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_c   = 1'b0;
        done_c    = 1'b0;
        skip_inc  = 1'b0;
        case (state)
            SKIP: begin
                if (SKIP_LIM == '0) begin
                    state_nxt = WAIT;
                end else if (fs) begin
                    skip_inc = 1'b1;
                    if (skip_cnt + 16'd1 >= SKIP_LIM) begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (fs && capture_en) begin
                    state_nxt = ACTIVE;
                    start_c   = 1'b1;
                end
            end
            ACTIVE: begin
                if (fs) begin
                    done_c = 1'b1;
                    if (capture_en) begin
                        start_c = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            default: state_nxt = SKIP;
        endcase
    end

    always_ff @(posedge cmos_pclk or posedge rst) begin
        if (rst) begin
            vs_r          <= 1'b0;
            hs_r          <= 1'b0;
            d_r           <= '0;
            vs_n_d        <= 1'b0;
            in_line_d     <= 1'b0;
            phase         <= 1'b0;
            hi_byte       <= '0;
            pix_cnt       <= '0;
            line_cnt      <= '0;
            err_acc       <= 1'b0;
            skip_cnt      <= '0;
            o_wr_en       <= 1'b0;
            o_wr_data     <= '0;
            o_frame_start <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_err   <= 1'b0;
            o_frame_cnt   <= '0;
        end else begin
            vs_r          <= cmos_vsync;
            hs_r          <= cmos_href;
            d_r           <= cmos_data;
            vs_n_d        <= vs_n;
            in_line_d     <= in_line;
            o_wr_en       <= 1'b0;
            o_frame_start <= start_c;
            o_frame_done  <= done_c;

            if (skip_inc) begin
                skip_cnt <= skip_cnt + 16'd1;
            end

            if (done_c) begin
                o_frame_err <= err_acc | (line_cnt != V_LIM);
                o_frame_cnt <= o_frame_cnt + 8'd1;
            end

            // Frame start wins over any pairing/line-end activity in the same cycle
            if (start_c) begin
                line_cnt <= '0;
                pix_cnt  <= '0;
                err_acc  <= 1'b0;
                phase    <= 1'b0;
            end else if (state == ACTIVE && in_line) begin
                if (!phase) begin
                    hi_byte <= d_r;
                    phase   <= 1'b1;
                end else begin
                    phase     <= 1'b0;
                    o_wr_data <= {hi_byte, d_r};
                    o_wr_en   <= (pix_cnt < H_LIM) && (line_cnt < V_LIM);
                    if (pix_cnt != CNT_MAX) begin
                        pix_cnt <= pix_cnt + 12'd1;
                    end
                end
            end else begin
                phase <= 1'b0;
                if (line_end) begin
                    if (line_cnt != CNT_MAX) begin
                        line_cnt <= line_cnt + 12'd1;
                    end
                    if (pix_cnt != H_LIM || phase) begin
                        err_acc <= 1'b1;
                    end
                    pix_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmos_rgb565_capture.sv
// Self-checking bench for cmos_rgb565_capture: random pixel bytes, a frame-level
// reference model and a write/frame scoreboard checked with immediate assertions.
module tb_cmos_rgb565_capture;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int SK = 2;

    logic        cmos_pclk = 1'b0;
    logic        rst = 1'b1;
    logic        cmos_vsync = 1'b0;
    logic        cmos_href = 1'b0;
    logic [7:0]  cmos_data = '0;
    logic        capture_en = 1'b1;
    logic        o_wr_en;
    logic [15:0] o_wr_data;
    logic        o_frame_start;
    logic        o_frame_done;
    logic        o_frame_err;
    logic [7:0]  o_frame_cnt;

    cmos_rgb565_capture #(
        .H_ACT(H),
        .V_ACT(V),
        .FRAME_SKIP(SK),
        .VSYNC_POL(1'b1)
    ) dut (
        .cmos_pclk(cmos_pclk),
        .rst(rst),
        .cmos_vsync(cmos_vsync),
        .cmos_href(cmos_href),
        .cmos_data(cmos_data),
        .capture_en(capture_en),
        .o_wr_en(o_wr_en),
        .o_wr_data(o_wr_data),
        .o_frame_start(o_frame_start),
        .o_frame_done(o_frame_done),
        .o_frame_err(o_frame_err),
        .o_frame_cnt(o_frame_cnt)
    );

    always #5 cmos_pclk = ~cmos_pclk;

    int cyc = 0;
    always @(posedge cmos_pclk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct { logic [15:0] data; int t; } wr_t;
    typedef struct { logic err; logic [7:0] cnt; logic start; } fr_t;
    wr_t exp_q[$];
    fr_t fr_q[$];

    int n_start = 0, n_done = 0, exp_start = 0, exp_done = 0;

    // Frame-level model: fs count since reset, whether the running frame is captured,
    // accumulated geometry error, completed lines, completed-frame counter.
    int         fs_cnt = 0;
    bit         cur_cap = 1'b0;
    bit         m_err = 1'b0;
    int         m_lines = 0;
    logic [7:0] m_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge cmos_pclk) begin : monitor
        wr_t e;
        fr_t r;
        if (o_wr_en) begin
            if (exp_q.size() == 0) begin
                chk("wr_en_unexpected", {31'd0, o_wr_en}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_data", {16'd0, o_wr_data}, {16'd0, e.data});
                chk("wr_time", cyc, e.t);
            end
        end
        if (o_frame_start) n_start++;
        if (o_frame_done) begin
            n_done++;
            if (fr_q.size() == 0) begin
                chk("done_unexpected", {31'd0, o_frame_done}, 32'd0);
            end else begin
                r = fr_q.pop_front();
                chk("done_err", {31'd0, o_frame_err}, {31'd0, r.err});
                chk("done_cnt", {24'd0, o_frame_cnt}, {24'd0, r.cnt});
                chk("done_with_start", {31'd0, o_frame_start}, {31'd0, r.start});
            end
        end
    end

    task automatic frame_sync();
        bit nxt;
        fs_cnt++;
        nxt = (fs_cnt > SK) && capture_en;
        if (cur_cap) begin
            m_cnt = m_cnt + 8'd1;
            fr_q.push_back('{err: m_err | (m_lines != V), cnt: m_cnt, start: nxt});
            exp_done++;
        end
        if (nxt) exp_start++;
        cur_cap = nxt;
        m_err   = 1'b0;
        m_lines = 0;
        @(negedge cmos_pclk);
        cmos_vsync = 1'b1;
        repeat (3) @(negedge cmos_pclk);
        cmos_vsync = 1'b0;
        repeat (4) @(negedge cmos_pclk);
    endtask

    task automatic send_line(input int nbytes, input bit special, input bit gap);
        logic [7:0] b, hi;
        hi = '0;
        for (int i = 0; i < nbytes; i++) begin
            @(negedge cmos_pclk);
            b = 8'($urandom);
            if (special && i == 0) b = 8'hF8;
            if (special && i == 1) b = 8'h1F;
            cmos_href = 1'b1;
            cmos_data = b;
            if (i % 2 == 0) begin
                hi = b;
            end else if (cur_cap && (i / 2) < H && m_lines < V) begin
                exp_q.push_back('{data: {hi, b}, t: cyc + 2});
            end
        end
        if (nbytes != 2 * H) m_err = 1'b1;
        m_lines++;
        if (gap) begin
            @(negedge cmos_pclk);
            cmos_href = 1'b0;
            repeat (3) @(negedge cmos_pclk);
        end
    endtask

    task automatic body(input int nlines, input int bad_line, input int bad_bytes, input bit special);
        for (int l = 0; l < nlines; l++) begin
            send_line((l == bad_line) ? bad_bytes : 2 * H, special && l == 0, 1'b1);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wr_en"}, {31'd0, o_wr_en}, 32'd0);
        chk({tag, "_wr_data"}, {16'd0, o_wr_data}, 32'd0);
        chk({tag, "_start"}, {31'd0, o_frame_start}, 32'd0);
        chk({tag, "_done"}, {31'd0, o_frame_done}, 32'd0);
        chk({tag, "_err"}, {31'd0, o_frame_err}, 32'd0);
        chk({tag, "_cnt"}, {24'd0, o_frame_cnt}, 32'd0);
    endtask

    task automatic sync_counts(input string tag);
        repeat (4) @(negedge cmos_pclk);
        chk({tag, "_starts"}, n_start, exp_start);
        chk({tag, "_dones"}, n_done, exp_done);
        chk({tag, "_pending_wr"}, exp_q.size(), 0);
        chk({tag, "_pending_fr"}, fr_q.size(), 0);
    endtask

    task automatic model_reset();
        fs_cnt  = 0;
        cur_cap = 1'b0;
        m_err   = 1'b0;
        m_lines = 0;
        m_cnt   = '0;
        exp_q.delete();
        fr_q.delete();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        capture_en = 1'b1;
        repeat (3) @(negedge cmos_pclk);
        check_zero("reset");
        model_reset();
        @(negedge cmos_pclk);
        rst = 1'b0;

        // settle skip: two frames dropped, frames 3 and 4 captured
        frame_sync(); body(4, -1, 0, 1'b0);
        frame_sync(); body(4, -1, 0, 1'b0);
        frame_sync(); body(4, -1, 0, 1'b1);
        frame_sync(); body(4, -1, 0, 1'b0);
        frame_sync();
        sync_counts("settle");
        chk("settle_cnt", {24'd0, o_frame_cnt}, 32'd2);
        chk("settle_err", {31'd0, o_frame_err}, 32'd0);

        // geometry errors
        body(4, 1, 20, 1'b0); frame_sync();
        chk("err_long_line", {31'd0, o_frame_err}, 32'd1);
        body(4, 2, 17, 1'b0); frame_sync();
        chk("err_odd_bytes", {31'd0, o_frame_err}, 32'd1);
        body(3, -1, 0, 1'b0); frame_sync();
        chk("err_short_frame", {31'd0, o_frame_err}, 32'd1);
        body(4, -1, 0, 1'b1); frame_sync();
        chk("err_clean", {31'd0, o_frame_err}, 32'd0);
        sync_counts("geom");

        // capture_en gating
        send_line(2 * H, 1'b0, 1'b1);
        capture_en = 1'b0;
        body(3, -1, 0, 1'b0);
        frame_sync();
        body(2, -1, 0, 1'b0);
        capture_en = 1'b1;
        body(2, -1, 0, 1'b0);
        frame_sync();
        body(4, -1, 0, 1'b0);
        frame_sync();
        sync_counts("gate");

        // back-to-back frames through the counter wrap
        for (int f = 0; f < 260; f++) frame_sync();
        sync_counts("b2b");
        chk("b2b_cnt", {24'd0, o_frame_cnt}, {24'd0, m_cnt});

        // reset mid-line
        send_line(2 * H, 1'b0, 1'b1);
        send_line(5, 1'b0, 1'b0);
        @(negedge cmos_pclk);
        #1;
        rst = 1'b1;
        cmos_href = 1'b0;
        model_reset();
        #1;
        check_zero("midrst");
        repeat (2) @(negedge cmos_pclk);
        rst = 1'b0;
        frame_sync(); body(4, -1, 0, 1'b0);
        frame_sync(); body(4, -1, 0, 1'b0);
        frame_sync(); body(4, -1, 0, 1'b0);
        frame_sync();
        sync_counts("after_rst");
        chk("after_rst_cnt", {24'd0, o_frame_cnt}, 32'd1);
        chk("after_rst_err", {31'd0, o_frame_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
